// File: rtl/gerenciador_de_patterns_param.sv
// gerenciador_de_patterns_param: step-driven pattern player with key-gated start/restart
// and a write-through pattern memory.
module gerenciador_de_patterns_param #(
    parameter int CMD_W  = 4,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int N_KEYS = 4,
    parameter int LOOP   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trocar_comando,
    input  logic [N_KEYS-1:0] KEY,
    input  logic              pausa,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CMD_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0] fim_da_lista,
    output logic [CMD_W-1:0]  prox_comando,
    output logic              comando_valido,
    output logic [ADDR_W-1:0] index,
    output logic [7:0]        voltas,
    output logic              fim_de_jogo
);
    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    state_t            state_q;
    logic [CMD_W-1:0]  mem_q [DEPTH];
    logic [CMD_W-1:0]  prox_q, rd_zero, rd_next;
    logic [ADDR_W-1:0] index_q, fim, idx_next;
    logic [7:0]        voltas_q;
    logic              solto_q, valido_q, fim_jogo_q;
    logic              wr_ok, keys_down, start, at_end;
    assign wr_ok     = wr_en && (32'(wr_addr) < DEPTH);
    assign fim       = (32'(fim_da_lista) < DEPTH - 1) ? fim_da_lista : LAST;
    assign idx_next  = index_q + ADDR_W'(1);
    assign keys_down = ~|KEY;
    assign start     = keys_down && solto_q;
    assign at_end    = index_q >= fim;
    // a write landing on the entry being loaded wins over the stale array value
    assign rd_zero   = (wr_en && wr_addr == '0) ? wr_data : mem_q[0];
    assign rd_next   = (wr_en && wr_addr == idx_next) ? wr_data : mem_q[idx_next];
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_addr] <= wr_data;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            index_q    <= '0;
            prox_q     <= '0;
            valido_q   <= 1'b0;
            fim_jogo_q <= 1'b0;
            voltas_q   <= 8'd0;
            solto_q    <= 1'b0;
        end else if (trocar_comando) begin
            if (!keys_down) solto_q <= 1'b1;
            case (state_q)
                IDLE: if (start) begin
                    state_q  <= PLAY;
                    index_q  <= '0;
                    prox_q   <= rd_zero;
                    valido_q <= 1'b1;
                    voltas_q <= 8'd0;
                    solto_q  <= 1'b0;
                end
                PLAY: if (!pausa) begin
                    if (!at_end) begin
                        index_q <= idx_next;
                        prox_q  <= rd_next;
                    end else if (LOOP != 0) begin
                        index_q <= '0;
                        prox_q  <= rd_zero;
                        if (voltas_q != 8'hFF) voltas_q <= voltas_q + 8'd1;
                    end else begin
                        state_q    <= DONE;
                        valido_q   <= 1'b0;
                        prox_q     <= '0;
                        fim_jogo_q <= 1'b1;
                    end
                end
                DONE: if (start) begin
                    state_q    <= IDLE;
                    index_q    <= '0;
                    fim_jogo_q <= 1'b0;
                    solto_q    <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign prox_comando   = prox_q;
    assign comando_valido = valido_q;
    assign index          = index_q;
    assign voltas         = voltas_q;
    assign fim_de_jogo    = fim_jogo_q;
endmodule

// File: doc/gerenciador_de_patterns_param.md
GERENCIADOR_DE_PATTERNS_PARAM -- requirements
Module: gerenciador_de_patterns_param

Interface
REQ-001 SHALL have parameter CMD_W, default 4, meaning the command width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, meaning the number of pattern memory entries.
REQ-003 SHALL have parameter ADDR_W, default 8, meaning the index width, with 2^ADDR_W >= DEPTH.
REQ-004 SHALL have parameter N_KEYS, default 4, meaning the number of player keys.
REQ-005 SHALL have parameter LOOP, default 0, where 1 means the pattern restarts at its end instead of finishing.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port trocar_comando, input, 1 bit: one-cycle step strobe, synchronous to clk.
REQ-009 SHALL have port KEY, input, N_KEYS bits: player keys, active-low (0 = pressed).
REQ-010 SHALL have port pausa, input, 1 bit: when 1, steps in PLAY are ignored.
REQ-011 SHALL have ports wr_en (1 bit), wr_addr (ADDR_W bits) and wr_data (CMD_W bits), all inputs: pattern memory write port.
REQ-012 SHALL have port fim_da_lista, input, ADDR_W bits: index of the last valid pattern entry.
REQ-013 SHALL have port prox_comando, output, CMD_W bits: current command, registered.
REQ-014 SHALL have port comando_valido, output, 1 bit: 1 while prox_comando is a live command.
REQ-015 SHALL have port index, output, ADDR_W bits: current pattern position.
REQ-016 SHALL have port voltas, output, 8 bits: completed-loop count, saturating.
REQ-017 SHALL have port fim_de_jogo, output, 1 bit: 1 in DONE.

Function
REQ-018 SHALL hold a DEPTH x CMD_W register-array memory; when wr_en=1 and wr_addr<DEPTH, mem[wr_addr] is written on the clk edge; writes with wr_addr>=DEPTH are dropped; writes are accepted in every state.
REQ-019 SHALL use an effective end index fim = min(fim_da_lista, DEPTH-1).
REQ-020 SHALL implement FSM states IDLE, PLAY and DONE; all state changes occur only on clk edges where trocar_comando=1.
REQ-021 SHALL keep an internal flag solto, set on any step that samples at least one KEY high and cleared when a start or restart is accepted.
REQ-022 IDLE: index=0, comando_valido=0, prox_comando=0, fim_de_jogo=0.
REQ-023 IDLE: a step with KEY all 0 and solto=1 SHALL move to PLAY with index<=0, prox_comando<=mem[0], comando_valido<=1 and voltas<=0.
REQ-024 PLAY: a step with pausa=0 and index<fim SHALL set index<=index+1 and prox_comando<=mem[index+1] in the same edge (zero-cycle read latency).
REQ-025 PLAY: a step with pausa=0 and index==fim, when LOOP=1, SHALL set index<=0, prox_comando<=mem[0], and voltas<=voltas+1, saturating at 255.
REQ-026 PLAY: a step with pausa=0 and index==fim, when LOOP=0, SHALL move to DONE with comando_valido<=0, prox_comando<=0 and fim_de_jogo<=1.
REQ-027 PLAY: a step with pausa=1 SHALL change nothing.
REQ-028 PLAY: fim_da_lista changed below the current index SHALL be treated as index==fim on the next step.
REQ-029 DONE: fim_de_jogo=1 SHALL hold; a step with KEY all 0 and solto=1 SHALL move to IDLE with fim_de_jogo<=0.
REQ-030 Write bypass: if wr_en=1 hits the address being loaded into prox_comando on the same edge, prox_comando SHALL take wr_data.
REQ-031 With fim=0, the single entry SHALL play for one step, then DONE (LOOP=0) or repeat (LOOP=1).

Reset
REQ-032 rst=0 SHALL asynchronously force IDLE, index=0, prox_comando=0, comando_valido=0, fim_de_jogo=0, voltas=0 and solto=0, including mid-PLAY.
REQ-033 Reset SHALL NOT clear memory contents.
REQ-034 After reset, keys SHALL be seen released on at least one step before a start is accepted.

Verification
REQ-035 Write mem[0..3]=1,2,3,4, fim_da_lista=3, LOOP=0, step with KEY=1111 then step with KEY=0000, then 4 steps -> prox_comando sequence 1,2,3,4, then fim_de_jogo=1, comando_valido=0, prox_comando=0.
REQ-036 LOOP=1, same data, 9 steps in PLAY -> prox_comando 1,2,3,4,1,2,3,4,1 with voltas=2; after 300 loops voltas=255.
REQ-037 pausa=1 during 3 steps at index=2 -> index stays 2 and prox_comando stays 3; release pausa -> next step gives index=3.
REQ-038 In DONE, KEY held 0000 across steps without release -> remains DONE; one step with KEY=1111 then KEY=0000 -> IDLE.
REQ-039 rst pulse low between edges mid-PLAY -> outputs 0 immediately; mem[0] still reads 1 after restart.
REQ-040 In PLAY at index=1, write wr_addr=2, wr_data=9 on the step edge -> prox_comando=9.
